instr_fetch: RTL and testbench

//  PC/fetch stage upstream of the instruction decoder (maindec/aludec controller).

---
 rtl/mips_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/instr_fetch.sv | 152 +++++++++++++++
 tb/tb_instr_fetch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch front end feeding the MIPS decoder.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

    // Circular pointer increment that also works for non-power-of-two depths.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1 == depth) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small {pc, instr} buffer between imem responses and decode; flush wins over push and pop.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  fetch_entry_t  i_push_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output fetch_entry_t  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= PW'(wrap_inc(32'(r_wr_ptr), DEPTH));
            end
            if (w_do_pop) begin
                r_rd_ptr <= PW'(wrap_inc(32'(r_rd_ptr), DEPTH));
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// PC/fetch stage: credit-limited imem reads, response tagging, redirect flush and drain.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                DEPTH    = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_discard;

    logic [ADDR_W-1:0] r_tag [DEPTH];
    logic [PW-1:0]     r_tag_wr;
    logic [PW-1:0]     r_tag_rd;

    logic          w_credit_ok;
    logic          w_issue;
    logic          w_resp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_out_next;
    logic [CW-1:0] w_discard_next;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    // Requests in flight plus buffered words never exceed DEPTH, so a push always has room.
    assign w_credit_ok = !w_full &&
                         (({1'b0, r_outstanding} + {1'b0, w_count}) < (CW + 1)'(DEPTH));

    assign imem_req  = (r_state == RUN) && !redirect_valid && w_credit_ok;
    assign imem_addr = r_pc;
    assign w_issue   = imem_req && imem_ready;

    // A response with nothing in flight is left over from before reset and is ignored.
    assign w_resp = imem_rvalid && (r_outstanding != '0);
    assign w_drop = w_resp && (r_discard != '0);
    assign w_push = w_resp && (r_discard == '0) && !redirect_valid;
    assign w_pop  = instr_valid && instr_ready;

    assign w_out_next = r_outstanding + CW'(w_issue) - CW'(w_resp);

    always_comb begin
        w_discard_next = r_discard;
        if (redirect_valid) begin
            w_discard_next = w_out_next;
        end else if (w_drop) begin
            w_discard_next = r_discard - CW'(1);
        end
    end

    assign w_push_entry.pc    = r_tag[r_tag_rd];
    assign w_push_entry.instr = imem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            r_discard     <= w_discard_next;

            if (redirect_valid) begin
                r_pc <= word_align(redirect_pc);
            end else if (w_issue) begin
                r_pc <= r_pc + ADDR_W'(4);
            end

            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (redirect_valid && (w_out_next != '0)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_discard_next == '0) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    // Address tag of every in-flight read, consumed in order by responses (kept or dropped).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
            r_tag_wr <= '0;
            r_tag_rd <= '0;
        end else begin
            if (w_issue) begin
                r_tag[r_tag_wr] <= r_pc;
                r_tag_wr        <= PW'(wrap_inc(32'(r_tag_wr), DEPTH));
            end
            if (w_resp) begin
                r_tag_rd <= PW'(wrap_inc(32'(r_tag_rd), DEPTH));
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign instr_valid = !w_empty;
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural imem with fixed latency, hand-computed expectations.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int n_issue = 0;
    int lat     = 1;
    bit resp_en = 1'b1;
    bit stray   = 1'b0;

    logic [31:0] q_addr[$];
    int          q_due[$];

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %-16s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("  ok %-16s %h", tag, got);
        end
    endtask

    task automatic drive_resp();
        if (resp_en && q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else if (stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    // One clock: record any issue at this edge, advance, then present the next response.
    task automatic tick();
        #1;
        if (imem_req && imem_ready) begin
            q_addr.push_back(imem_addr);
            q_due.push_back(cyc + lat);
            n_issue++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drive_resp();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        stray          = 1'b0;
        q_addr.delete();
        q_due.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        n_issue = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst_req", 32'(imem_req), 32'd0);
        check_val("rst_valid", 32'(instr_valid), 32'd0);
        check_val("rst_instr", instr, 32'h0);
        check_val("rst_instr_pc", instr_pc, 32'h0);
        check_val("rst_addr", imem_addr, 32'h0);

        // 1: boot cycle, then sequential fetch, first instr 3 edges after release
        do_reset();
        #1;
        check_val("t1_boot_req", 32'(imem_req), 32'd0);
        tick();
        check_val("t1_run_req", 32'(imem_req), 32'd1);
        check_val("t1_addr0", imem_addr, 32'h0);
        tick();
        check_val("t1_valid_e1", 32'(instr_valid), 32'd0);
        check_val("t1_addr4", imem_addr, 32'h4);
        tick();
        check_val("t1_valid_e2", 32'(instr_valid), 32'd1);
        check_val("t1_pc", instr_pc, 32'h0);
        check_val("t1_instr", instr, word_of(32'h0));

        // 2: backpressure stops issue at the credit limit, then drains in order
        check_val("t2_req_full", 32'(imem_req), 32'd0);
        tick();
        tick();
        check_val("t2_issues", 32'(n_issue), 32'd2);
        check_val("t2_req_hold", 32'(imem_req), 32'd0);
        check_val("t2_head", instr_pc, 32'h0);
        instr_ready = 1'b1;
        tick();
        check_val("t2_pop_pc", instr_pc, 32'h4);
        check_val("t2_pop_instr", instr, word_of(32'h4));
        check_val("t2_resume_addr", imem_addr, 32'h8);
        check_val("t2_resume_req", 32'(imem_req), 32'd1);
        tick();
        check_val("t2_empty", 32'(instr_valid), 32'd0);
        tick();
        check_val("t2_pc8", instr_pc, 32'h8);

        // 3: imem not ready holds the request and address
        imem_ready = 1'b0;
        instr_ready = 1'b1;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("t3_req_held", 32'(imem_req), 32'd1);
            check_val("t3_addr_held", imem_addr, 32'h0);
            tick();
        end
        check_val("t3_no_issue", 32'(n_issue), 32'd0);
        imem_ready = 1'b1;
        tick();
        check_val("t3_addr4", imem_addr, 32'h4);
        check_val("t3_one_issue", 32'(n_issue), 32'd1);
        tick();
        check_val("t3_pc0", instr_pc, 32'h0);
        check_val("t3_two_issue", 32'(n_issue), 32'd2);

        // 4: redirect with two reads in flight; both responses dropped
        do_reset();
        resp_en = 1'b0;
        tick();
        tick();
        tick();
        check_val("t4_req_full", 32'(imem_req), 32'd0);
        check_val("t4_issues", 32'(n_issue), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        resp_en        = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_val("t4_flush", 32'(instr_valid), 32'd0);
        check_val("t4_drain_req", 32'(imem_req), 32'd0);
        check_val("t4_new_pc", imem_addr, 32'h40);
        tick();
        check_val("t4_drop1", 32'(instr_valid), 32'd0);
        check_val("t4_drain_req2", 32'(imem_req), 32'd0);
        tick();
        check_val("t4_run_req", 32'(imem_req), 32'd1);
        check_val("t4_run_addr", imem_addr, 32'h40);
        tick();
        tick();
        check_val("t4_pc40", instr_pc, 32'h40);
        check_val("t4_instr40", instr, word_of(32'h40));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        #1;
        check_val("t4_redir_noreq", 32'(imem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check_val("t4_align_addr", imem_addr, 32'h40);
        check_val("t4_align_flush", 32'(instr_valid), 32'd0);
        check_val("t4_align_req", 32'(imem_req), 32'd1);

        // 5: redirect coinciding with a response and a pop; then address wrap
        instr_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        check_val("t5_valid", 32'(instr_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        instr_ready    = 1'b1;
        #1;
        check_val("t5_redir_noreq", 32'(imem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check_val("t5_flush", 32'(instr_valid), 32'd0);
        check_val("t5_issues", 32'(n_issue), 32'd2);
        check_val("t5_addr", imem_addr, 32'h100);
        check_val("t5_req_run", 32'(imem_req), 32'd1);
        tick();
        tick();
        check_val("t5_pc100", instr_pc, 32'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_val("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
        check_val("t5_top_req", 32'(imem_req), 32'd1);
        tick();
        check_val("t5_wrap_addr", imem_addr, 32'h0);
        tick();
        check_val("t5_top_pc", instr_pc, 32'hFFFF_FFFC);
        check_val("t5_top_instr", instr, word_of(32'hFFFF_FFFC));

        // 6: asynchronous reset with two reads in flight; stale response ignored
        instr_ready = 1'b0;
        do_reset();
        resp_en = 1'b0;
        tick();
        tick();
        tick();
        check_val("t6_pre_addr", imem_addr, 32'h8);
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_req", 32'(imem_req), 32'd0);
        check_val("t6_rst_addr", imem_addr, 32'h0);
        check_val("t6_rst_valid", 32'(instr_valid), 32'd0);
        check_val("t6_rst_instr", instr, 32'h0);
        check_val("t6_rst_pc", instr_pc, 32'h0);
        q_addr.delete();
        q_due.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        n_issue     = 0;
        resp_en     = 1'b1;
        stray       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        check_val("t6_stray_boot", 32'(instr_valid), 32'd0);
        tick();
        stray = 1'b0;
        check_val("t6_stray_run", 32'(instr_valid), 32'd0);
        tick();
        check_val("t6_restart_pc", instr_pc, 32'h0);
        check_val("t6_restart_ins", instr, word_of(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
